// File: rtl/settings_bus_arbiter_if.sv
// Requester-side and settings-bus signals of settings_bus_arbiter, bundled with arbiter/requester modports.
// Master i occupies slice [i*W +: W] of the packed per-master address and write-data vectors.
interface settings_bus_arbiter_if #(
  parameter int C_DATAWIDTH   = 32,
  parameter int C_ADDRWIDTH   = 32,
  parameter int C_NUM_MASTERS = 2
);
  logic [C_NUM_MASTERS-1:0]             m_req;
  logic [C_NUM_MASTERS-1:0]             m_wr;
  logic [C_NUM_MASTERS*C_ADDRWIDTH-1:0] m_addr;
  logic [C_NUM_MASTERS*C_DATAWIDTH-1:0] m_wdata;
  logic [C_NUM_MASTERS-1:0]             m_ack;
  logic [C_DATAWIDTH-1:0]               m_rdata;
  logic                                 set_stb;
  logic [C_ADDRWIDTH-1:0]               set_addr;
  logic [C_DATAWIDTH-1:0]               set_data;
  logic                                 get_stb;
  logic [C_ADDRWIDTH-1:0]               get_addr;
  logic [C_DATAWIDTH-1:0]               get_data;

  modport slave (
    input  m_req, m_wr, m_addr, m_wdata, get_data,
    output m_ack, m_rdata, set_stb, set_addr, set_data, get_stb, get_addr
  );

  modport master (
    output m_req, m_wr, m_addr, m_wdata, get_data,
    input  m_ack, m_rdata, set_stb, set_addr, set_data, get_stb, get_addr
  );
endinterface

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing one settings bus among C_NUM_MASTERS requesters; 3 cycles req->ack, no pipelining.
// Requesters hold m_req until m_ack; define SETTINGS_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module settings_bus_arbiter #(
  parameter int C_DATAWIDTH   = 32,
  parameter int C_ADDRWIDTH   = 32,
  parameter int C_NUM_MASTERS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  settings_bus_arbiter_if.slave bus
);
  localparam int GW = (C_NUM_MASTERS > 1) ? $clog2(C_NUM_MASTERS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                   r_state, w_state_nxt;
  logic [GW-1:0]            r_grant, w_grant_nxt;
  logic                     r_wr, w_wr_nxt;
  logic                     r_set_stb, w_set_stb_nxt;
  logic                     r_get_stb, w_get_stb_nxt;
  logic [C_ADDRWIDTH-1:0]   r_set_addr, w_set_addr_nxt;
  logic [C_ADDRWIDTH-1:0]   r_get_addr, w_get_addr_nxt;
  logic [C_DATAWIDTH-1:0]   r_set_data, w_set_data_nxt;
  logic [C_DATAWIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic [C_NUM_MASTERS-1:0] r_ack, w_ack_nxt;

  logic                     w_found;
  logic [GW-1:0]            w_pick;
  logic [GW-1:0]            w_cand;
  logic                     w_sel_wr;
  logic [C_ADDRWIDTH-1:0]   w_sel_addr;
  logic [C_DATAWIDTH-1:0]   w_sel_wdata;

`ifndef SETTINGS_ARB_FIXED_PRIO_EN
  logic [GW-1:0]            r_last_grant, w_last_grant_nxt;
`endif

  // Winner search: from last_grant+1 with wrap, or from index 0 under fixed priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
`ifdef SETTINGS_ARB_FIXED_PRIO_EN
    for (int k = 0; k < C_NUM_MASTERS; k++) begin
      w_cand = GW'(k);
      if (!w_found && bus.m_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
`else
    for (int k = 1; k <= C_NUM_MASTERS; k++) begin
      w_cand = GW'((int'(r_last_grant) + k) % C_NUM_MASTERS);
      if (!w_found && bus.m_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
`endif
  end

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < C_NUM_MASTERS; k++) begin
      if (w_pick == GW'(k)) begin
        w_sel_wr    = bus.m_wr[k];
        w_sel_addr  = bus.m_addr[k*C_ADDRWIDTH +: C_ADDRWIDTH];
        w_sel_wdata = bus.m_wdata[k*C_DATAWIDTH +: C_DATAWIDTH];
      end
    end
  end

  // Strobes and ack are registered, so each is loaded on the edge entering the state that shows it.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_wr_nxt       = r_wr;
    w_set_stb_nxt  = 1'b0;
    w_get_stb_nxt  = 1'b0;
    w_set_addr_nxt = r_set_addr;
    w_set_data_nxt = r_set_data;
    w_get_addr_nxt = r_get_addr;
    w_rdata_nxt    = '0;
    w_ack_nxt      = '0;
`ifndef SETTINGS_ARB_FIXED_PRIO_EN
    w_last_grant_nxt = r_last_grant;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_ISSUE;
          w_grant_nxt = w_pick;
          w_wr_nxt    = w_sel_wr;
          if (w_sel_wr) begin
            w_set_stb_nxt  = 1'b1;
            w_set_addr_nxt = w_sel_addr;
            w_set_data_nxt = w_sel_wdata;
          end else begin
            w_get_stb_nxt  = 1'b1;
            w_get_addr_nxt = w_sel_addr;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt        = S_RESP;
        w_ack_nxt[r_grant] = 1'b1;
        w_rdata_nxt        = r_wr ? '0 : bus.get_data;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
`ifndef SETTINGS_ARB_FIXED_PRIO_EN
        w_last_grant_nxt = r_grant;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_wr       <= 1'b0;
      r_set_stb  <= 1'b0;
      r_get_stb  <= 1'b0;
      r_set_addr <= '0;
      r_set_data <= '0;
      r_get_addr <= '0;
      r_rdata    <= '0;
      r_ack      <= '0;
`ifndef SETTINGS_ARB_FIXED_PRIO_EN
      r_last_grant <= GW'(C_NUM_MASTERS - 1);
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_wr       <= w_wr_nxt;
      r_set_stb  <= w_set_stb_nxt;
      r_get_stb  <= w_get_stb_nxt;
      r_set_addr <= w_set_addr_nxt;
      r_set_data <= w_set_data_nxt;
      r_get_addr <= w_get_addr_nxt;
      r_rdata    <= w_rdata_nxt;
      r_ack      <= w_ack_nxt;
`ifndef SETTINGS_ARB_FIXED_PRIO_EN
      r_last_grant <= w_last_grant_nxt;
`endif
    end
  end

  assign bus.m_ack    = r_ack;
  assign bus.m_rdata  = r_rdata;
  assign bus.set_stb  = r_set_stb;
  assign bus.set_addr = r_set_addr;
  assign bus.set_data = r_set_data;
  assign bus.get_stb  = r_get_stb;
  assign bus.get_addr = r_get_addr;
endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Directed bench for settings_bus_arbiter: single-transaction vector table plus contention, back-to-back,
// withdrawal and mid-transaction reset sequences against a small combinational settings-bus read model.
module tb_settings_bus_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  settings_bus_arbiter_if #(.C_DATAWIDTH(DW), .C_ADDRWIDTH(AW), .C_NUM_MASTERS(N)) bus ();

  settings_bus_arbiter #(.C_DATAWIDTH(DW), .C_ADDRWIDTH(AW), .C_NUM_MASTERS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register-file model: address 0 returns a fixed pattern, others a tag of the address.
  assign bus.get_data = (bus.get_addr == '0) ? 32'hACE0BA53 : (bus.get_addr ^ 32'h5A5A0000);

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.set_stb && bus.get_stb) begin
      n_miss++;
      $display("FAIL strobe_overlap: got set_stb=1 get_stb=1, expected at most one");
    end
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0, a1, d0, d1;
    logic        exp_set;
    logic        exp_get;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int got;

    bus.m_req   = '0;
    bus.m_wr    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;

    //            req    wr     a0     a1     d0            d1            set get exp_addr exp_data      ack    rdata
    tbl[0] = '{2'b01, 2'b01, 32'h4,  32'h0,  32'h1F,       32'h0,        1, 0, 32'h4,   32'h1F,       2'b01, 32'h0};
    tbl[1] = '{2'b10, 2'b00, 32'h0,  32'h0,  32'h0,        32'h0,        0, 1, 32'h0,   32'h0,        2'b10, 32'hACE0BA53};
    tbl[2] = '{2'b11, 2'b01, 32'h10, 32'h20, 32'hDEADBEEF, 32'h0,        1, 0, 32'h10,  32'hDEADBEEF, 2'b01, 32'h0};
    tbl[3] = '{2'b11, 2'b01, 32'h10, 32'h20, 32'hDEADBEEF, 32'h0,        0, 1, 32'h20,  32'h0,        2'b10, 32'h5A5A0020};
    tbl[4] = '{2'b10, 2'b10, 32'h0,  32'h30, 32'h0,        32'h12345678, 1, 0, 32'h30,  32'h12345678, 2'b10, 32'h0};
    tbl[5] = '{2'b11, 2'b10, 32'h44, 32'h30, 32'h0,        32'h12345678, 0, 1, 32'h44,  32'h0,        2'b01, 32'h5A5A0044};
    tbl[6] = '{2'b01, 2'b01, 32'h8,  32'h0,  32'hCAFEF00D, 32'h0,        1, 0, 32'h8,   32'hCAFEF00D, 2'b01, 32'h0};
    tbl[7] = '{2'b11, 2'b01, 32'h8,  32'h0,  32'hCAFEF00D, 32'h0,        0, 1, 32'h0,   32'h0,        2'b10, 32'hACE0BA53};

    repeat (2) @(posedge clk);
    #1;
    chk("rst m_ack",    32'(bus.m_ack),   32'h0);
    chk("rst m_rdata",  bus.m_rdata,      32'h0);
    chk("rst set_stb",  32'(bus.set_stb), 32'h0);
    chk("rst get_stb",  32'(bus.get_stb), 32'h0);
    chk("rst set_addr", bus.set_addr,     32'h0);
    chk("rst set_data", bus.set_data,     32'h0);
    chk("rst get_addr", bus.get_addr,     32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.m_req   = tbl[i].req;
      bus.m_wr    = tbl[i].wr;
      bus.m_addr  = {tbl[i].a1, tbl[i].a0};
      bus.m_wdata = {tbl[i].d1, tbl[i].d0};
      @(posedge clk);
      #1;
      chk($sformatf("v%0d issue set_stb", i), 32'(bus.set_stb), 32'(tbl[i].exp_set));
      chk($sformatf("v%0d issue get_stb", i), 32'(bus.get_stb), 32'(tbl[i].exp_get));
      chk($sformatf("v%0d issue m_ack", i),   32'(bus.m_ack),   32'h0);
      if (tbl[i].exp_set) begin
        chk($sformatf("v%0d set_addr", i), bus.set_addr, tbl[i].exp_addr);
        chk($sformatf("v%0d set_data", i), bus.set_data, tbl[i].exp_data);
      end else begin
        chk($sformatf("v%0d get_addr", i), bus.get_addr, tbl[i].exp_addr);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d resp m_ack", i),   32'(bus.m_ack),   32'(tbl[i].exp_ack));
      chk($sformatf("v%0d resp m_rdata", i), bus.m_rdata,      tbl[i].exp_rdata);
      chk($sformatf("v%0d resp strobes", i), 32'({bus.set_stb, bus.get_stb}), 32'h0);
      bus.m_req = '0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d idle m_ack", i), 32'(bus.m_ack), 32'h0);
    end

    // The last table entry was a read, so the write bus still shows the previous write.
    chk("hold set_addr", bus.set_addr, 32'h8);
    chk("hold set_data", bus.set_data, 32'hCAFEF00D);

    // Both masters request continuously: alternating grants, one ack every 3 cycles.
    @(negedge clk);
    bus.m_req   = 2'b11;
    bus.m_wr    = 2'b11;
    bus.m_addr  = {32'h200, 32'h100};
    bus.m_wdata = {32'h2, 32'h1};
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.m_ack != '0) begin
        chk($sformatf("rr ack%0d cycle", got), 32'(c), 32'(1 + 3 * got));
`ifdef SETTINGS_ARB_FIXED_PRIO_EN
        chk($sformatf("rr ack%0d master", got), 32'(bus.m_ack), 32'h1);
`else
        chk($sformatf("rr ack%0d master", got), 32'(bus.m_ack), (got % 2 == 0) ? 32'h1 : 32'h2);
`endif
        got++;
        if (got == 4) bus.m_req = '0;
      end
    end
    chk("rr ack count", 32'(got), 32'h4);
    @(posedge clk);

    // Master 1 alone, three back-to-back reads.
    @(negedge clk);
    bus.m_req  = 2'b10;
    bus.m_wr   = 2'b00;
    bus.m_addr = {32'h20, 32'h0};
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.m_ack != '0) begin
        chk($sformatf("b2b ack%0d cycle", got),  32'(c), 32'(1 + 3 * got));
        chk($sformatf("b2b ack%0d master", got), 32'(bus.m_ack), 32'h2);
        chk($sformatf("b2b ack%0d rdata", got),  bus.m_rdata, 32'h5A5A0020);
        got++;
        if (got == 3) bus.m_req = '0;
      end
    end
    chk("b2b ack count", 32'(got), 32'h3);
    @(posedge clk);

    // Request withdrawn and inputs changed right after latching: access still completes unchanged.
    @(negedge clk);
    bus.m_req   = 2'b01;
    bus.m_wr    = 2'b01;
    bus.m_addr  = {32'h0, 32'h50};
    bus.m_wdata = {32'h0, 32'h55};
    @(posedge clk);
    #1;
    chk("wd set_stb",  32'(bus.set_stb), 32'h1);
    chk("wd set_addr", bus.set_addr,     32'h50);
    bus.m_req   = '0;
    bus.m_wr    = '0;
    bus.m_addr  = {32'h0, 32'h99};
    bus.m_wdata = '0;
    @(posedge clk);
    #1;
    chk("wd ack",      32'(bus.m_ack), 32'h1);
    @(posedge clk);
    #1;
    chk("wd no ack1",  32'(bus.m_ack), 32'h0);
    @(posedge clk);
    #1;
    chk("wd no ack2",  32'(bus.m_ack), 32'h0);
    chk("wd hold addr", bus.set_addr,  32'h50);
    chk("wd hold data", bus.set_data,  32'h55);

    // Reset during ISSUE of a read from master 1 (master 0 was granted last).
    @(negedge clk);
    bus.m_req  = 2'b10;
    bus.m_wr   = 2'b00;
    bus.m_addr = {32'h20, 32'h0};
    @(posedge clk);
    #1;
    chk("rst issue get_stb", 32'(bus.get_stb), 32'h1);
    rst       = 1'b1;
    bus.m_req = '0;
    @(posedge clk);
    #1;
    chk("abort m_ack",    32'(bus.m_ack),   32'h0);
    chk("abort get_stb",  32'(bus.get_stb), 32'h0);
    chk("abort set_stb",  32'(bus.set_stb), 32'h0);
    chk("abort get_addr", bus.get_addr,     32'h0);
    chk("abort set_addr", bus.set_addr,     32'h0);
    chk("abort m_rdata",  bus.m_rdata,      32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post rst no ack", 32'(bus.m_ack), 32'h0);
    @(negedge clk);
    bus.m_req  = 2'b11;
    bus.m_wr   = 2'b00;
    bus.m_addr = {32'h20, 32'h44};
    @(posedge clk);
    #1;
    chk("post rst get_addr", bus.get_addr, 32'h44);
    @(posedge clk);
    #1;
    chk("post rst ack m0", 32'(bus.m_ack), 32'h1);
    chk("post rst rdata",  bus.m_rdata,    32'h5A5A0044);
    bus.m_req = '0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
